// File: rtl/rom_arbiter_pkg.sv
// Shared constants and helpers for the instruction-ROM arbiter: memory map,
// data width, default fetch-starvation limit and the range-check function.
package rom_arbiter_pkg;

  localparam int unsigned XLEN                = 32;
  localparam logic [XLEN-1:0] MEM_OFFSET      = 32'h8000_0000;
  localparam logic [XLEN-1:0] MEM_SIZE        = 32'h0000_4000;
  localparam int unsigned PART_ADDR_WIDTH     = 14;
  localparam int unsigned ROM_IF_STARVE_LIMIT = 4;

  // Which requester, if any, owns the ROM port in the current cycle.
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_IF   = 2'd1,
    GNT_LS   = 2'd2
  } gnt_sel_e;

  // Evaluated one bit wider than XLEN so MEM_OFFSET+MEM_SIZE cannot wrap.
  function automatic logic addr_in_range(input logic [XLEN-1:0] addr);
    logic [XLEN:0] a;
    logic [XLEN:0] lo;
    logic [XLEN:0] hi;
    a  = {1'b0, addr};
    lo = {1'b0, MEM_OFFSET};
    hi = lo + {1'b0, MEM_SIZE};
    return (a >= lo) && (a < hi);
  endfunction

endpackage

// File: rtl/rom_arbiter_if.sv
// Bundle of the fetch port, load/store port and ROM connection seen by rom_arbiter.
interface rom_arbiter_if;
  import rom_arbiter_pkg::*;

  // Handshake: a request is accepted in the cycle where req and gnt are both
  // high; the requester holds req/addr until then and may drop req beforehand
  // with no side effects. The response (valid/data/err) arrives exactly one
  // cycle after acceptance.
  logic            if_req_i;
  logic [XLEN-1:0] if_addr_i;
  logic            if_flush_i;
  logic            if_gnt_o;
  logic            if_valid_o;
  logic [XLEN-1:0] if_data_o;
  logic            if_err_o;

  logic            ls_req_i;
  logic [XLEN-1:0] ls_addr_i;
  logic            ls_gnt_o;
  logic            ls_valid_o;
  logic [XLEN-1:0] ls_data_o;
  logic            ls_err_o;

  logic [XLEN-1:0] rom_addr_o;
  logic [XLEN-1:0] rom_data_i;

  modport slave (
    input  if_req_i, if_addr_i, if_flush_i, ls_req_i, ls_addr_i, rom_data_i,
    output if_gnt_o, if_valid_o, if_data_o, if_err_o,
           ls_gnt_o, ls_valid_o, ls_data_o, ls_err_o, rom_addr_o
  );

  modport master (
    output if_req_i, if_addr_i, if_flush_i, ls_req_i, ls_addr_i, rom_data_i,
    input  if_gnt_o, if_valid_o, if_data_o, if_err_o,
           ls_gnt_o, ls_valid_o, ls_data_o, ls_err_o, rom_addr_o
  );

endinterface

// File: rtl/rom_arbiter.sv
// Shares the synchronous-read instruction ROM between IF fetch and load/store
// reads: combinational grant, one-cycle response routing, range screening.
module rom_arbiter
  import rom_arbiter_pkg::*;
#(
  parameter int unsigned IF_STARVE_LIMIT = ROM_IF_STARVE_LIMIT
) (
  input  logic         clk_i,
  input  logic         rst_i,
  rom_arbiter_if.slave bus
);

  localparam int unsigned SW = (IF_STARVE_LIMIT < 2) ? 1 : $clog2(IF_STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = (IF_STARVE_LIMIT < 1) ? SW'(1) : SW'(IF_STARVE_LIMIT);

  gnt_sel_e      sel;
  logic          at_limit;
  logic [SW-1:0] starve_q, starve_d;
  logic          resp_if_q, resp_if_d;
  logic          resp_ls_q, resp_ls_d;
  logic          oor_q, oor_d;
  logic          if_valid;

  // Load/store wins by default; fetch takes the port once it has waited
  // LIMIT consecutive load grants. A flush blocks fetch outright.
  always_comb begin
    sel      = GNT_NONE;
    at_limit = (starve_q == LIMIT);
    if (!rst_i) begin
      if (bus.if_req_i && !bus.if_flush_i && (!bus.ls_req_i || at_limit)) begin
        sel = GNT_IF;
      end else if (bus.ls_req_i) begin
        sel = GNT_LS;
      end
    end
  end

  assign bus.if_gnt_o   = (sel == GNT_IF);
  assign bus.ls_gnt_o   = (sel == GNT_LS);
  assign bus.rom_addr_o = (sel == GNT_LS) ? bus.ls_addr_i : bus.if_addr_i;

  // The counter saturates at LIMIT: a flush at the limit keeps fetch
  // first in line rather than letting the count run past it.
  always_comb begin
    resp_if_d = (sel == GNT_IF);
    resp_ls_d = (sel == GNT_LS);
    oor_d     = (sel != GNT_NONE) && !addr_in_range(bus.rom_addr_o);
    starve_d  = starve_q;
    if ((sel == GNT_IF) || !bus.if_req_i) begin
      starve_d = '0;
    end else if ((sel == GNT_LS) && !at_limit) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      starve_q  <= '0;
      resp_if_q <= 1'b0;
      resp_ls_q <= 1'b0;
      oor_q     <= 1'b0;
    end else begin
      starve_q  <= starve_d;
      resp_if_q <= resp_if_d;
      resp_ls_q <= resp_ls_d;
      oor_q     <= oor_d;
    end
  end

  // A flush during the response cycle kills the fetched word.
  assign if_valid       = resp_if_q & ~bus.if_flush_i;
  assign bus.if_valid_o = if_valid;
  assign bus.if_err_o   = if_valid & oor_q;
  assign bus.if_data_o  = (if_valid && !oor_q) ? bus.rom_data_i : '0;

  assign bus.ls_valid_o = resp_ls_q;
  assign bus.ls_err_o   = resp_ls_q & oor_q;
  assign bus.ls_data_o  = (resp_ls_q && !oor_q) ? bus.rom_data_i : '0;

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed and random stimulus for rom_arbiter, checked every cycle against a
// behavioural model of the arbitration rules and a model ROM.
module tb_rom_arbiter;
  import rom_arbiter_pkg::*;

  localparam int unsigned LIMIT = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rom_arbiter_if bus();

  rom_arbiter #(.IF_STARVE_LIMIT(LIMIT)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // model state
  int          streak = 0;
  logic        pend_if = 1'b0;
  logic        pend_ls = 1'b0;
  logic [31:0] pend_addr = '0;

  // last observed values, for directed checks
  logic        obs_if_gnt, obs_ls_gnt;
  logic        obs_if_valid, obs_ls_valid, obs_ls_err;
  logic [31:0] obs_if_data, obs_ls_data;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (w == MEM_OFFSET + 32'h10) return 32'h0050_0093;
    return {w[15:0], ~w[15:0]} ^ 32'h1357_9bdf;
  endfunction

  function automatic logic in_map(input logic [31:0] a);
    longint la;
    la = longint'(a);
    return (la >= longint'(MEM_OFFSET)) && (la < longint'(MEM_OFFSET) + longint'(MEM_SIZE));
  endfunction

  function automatic logic [31:0] rand_addr();
    int sel;
    sel = $urandom_range(0, 9);
    case (sel)
      0: return MEM_OFFSET + MEM_SIZE;
      1: return MEM_OFFSET + MEM_SIZE - 32'd4;
      2: return MEM_OFFSET - 32'd4;
      3: return $urandom;
      default: return MEM_OFFSET + ($urandom_range(0, 255) << 2) + 32'($urandom_range(0, 3));
    endcase
  endfunction

  always @(posedge clk) bus.rom_data_i <= rom_word(bus.rom_addr_o);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, check at mid-cycle, advance model, step clock.
  task automatic cycle(input logic ir, input logic [31:0] ia, input logic fl,
                       input logic lr, input logic [31:0] la, input logic r);
    logic win_if, win_ls, ev_if, ev_ls, ok;
    logic [31:0] exp_addr;
    bus.if_req_i   = ir;
    bus.if_addr_i  = ia;
    bus.if_flush_i = fl;
    bus.ls_req_i   = lr;
    bus.ls_addr_i  = la;
    rst            = r;
    #4;
    win_if   = !r && ir && !fl && (!lr || streak >= int'(LIMIT));
    win_ls   = !r && lr && !win_if;
    exp_addr = win_ls ? la : ia;
    ev_if    = pend_if && !fl;
    ev_ls    = pend_ls;
    ok       = in_map(pend_addr);
    chk("if_gnt",   32'(bus.if_gnt_o), 32'(win_if));
    chk("ls_gnt",   32'(bus.ls_gnt_o), 32'(win_ls));
    chk("rom_addr", bus.rom_addr_o, exp_addr);
    chk("if_valid", 32'(bus.if_valid_o), 32'(ev_if));
    chk("if_err",   32'(bus.if_err_o), 32'(ev_if && !ok));
    chk("if_data",  bus.if_data_o, (ev_if && ok) ? rom_word(pend_addr) : 32'h0);
    chk("ls_valid", 32'(bus.ls_valid_o), 32'(ev_ls));
    chk("ls_err",   32'(bus.ls_err_o), 32'(ev_ls && !ok));
    chk("ls_data",  bus.ls_data_o, (ev_ls && ok) ? rom_word(pend_addr) : 32'h0);
    obs_if_gnt   = bus.if_gnt_o;
    obs_ls_gnt   = bus.ls_gnt_o;
    obs_if_valid = bus.if_valid_o;
    obs_if_data  = bus.if_data_o;
    obs_ls_valid = bus.ls_valid_o;
    obs_ls_data  = bus.ls_data_o;
    obs_ls_err   = bus.ls_err_o;
    pend_if   = win_if;
    pend_ls   = win_ls;
    pend_addr = exp_addr;
    if (r || win_if || !ir) streak = 0;
    else if (win_ls)        streak = streak + 1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, MEM_OFFSET, 1'b0, 1'b0, MEM_OFFSET, 1'b0);
  endtask

  logic [31:0] gpat;
  logic        rq_if, rq_ls, rfl, rrst;
  logic [31:0] ra_if, ra_ls;

  initial begin
    rst            = 1'b1;
    bus.if_req_i   = 1'b0;
    bus.if_addr_i  = MEM_OFFSET;
    bus.if_flush_i = 1'b0;
    bus.ls_req_i   = 1'b0;
    bus.ls_addr_i  = MEM_OFFSET;
    repeat (2) @(posedge clk);
    #1;

    // reset state
    cycle(1'b0, MEM_OFFSET, 1'b0, 1'b0, MEM_OFFSET, 1'b0);

    // IF-only fetch
    cycle(1'b1, MEM_OFFSET + 32'h10, 1'b0, 1'b0, MEM_OFFSET, 1'b0);
    chk("ifonly_gnt", 32'(obs_if_gnt), 32'h1);
    idle();
    chk("ifonly_valid", 32'(obs_if_valid), 32'h1);
    chk("ifonly_data", obs_if_data, 32'h0050_0093);

    // both requesting: LS,LS,LS,LS,IF,LS
    gpat = '0;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, MEM_OFFSET + 32'h200, 1'b0, 1'b1, MEM_OFFSET + 32'h100 + 32'(i * 4), 1'b0);
      gpat[i] = obs_if_gnt;
    end
    chk("both_pattern", gpat, 32'h10);
    idle();
    chk("both_last_ls_valid", 32'(obs_ls_valid), 32'h1);
    chk("both_last_ls_data", obs_ls_data, rom_word(MEM_OFFSET + 32'h114));

    // flush in grant cycle, redirect accepted next cycle
    cycle(1'b1, MEM_OFFSET + 32'h20, 1'b1, 1'b0, MEM_OFFSET, 1'b0);
    chk("flush_gnt_blocked", 32'(obs_if_gnt), 32'h0);
    cycle(1'b1, MEM_OFFSET + 32'h40, 1'b0, 1'b0, MEM_OFFSET, 1'b0);
    chk("redirect_gnt", 32'(obs_if_gnt), 32'h1);
    idle();
    chk("redirect_data", obs_if_data, rom_word(MEM_OFFSET + 32'h40));

    // flush in response cycle
    cycle(1'b1, MEM_OFFSET + 32'h50, 1'b0, 1'b0, MEM_OFFSET, 1'b0);
    cycle(1'b0, MEM_OFFSET, 1'b1, 1'b0, MEM_OFFSET, 1'b0);
    chk("flush_resp_killed", 32'(obs_if_valid), 32'h0);
    idle();
    chk("flush_no_late", 32'(obs_if_valid), 32'h0);

    // range boundaries
    cycle(1'b0, MEM_OFFSET, 1'b0, 1'b1, MEM_OFFSET + MEM_SIZE, 1'b0);
    idle();
    chk("oor_err", 32'(obs_ls_err), 32'h1);
    chk("oor_data", obs_ls_data, 32'h0);
    cycle(1'b0, MEM_OFFSET, 1'b0, 1'b1, MEM_OFFSET + MEM_SIZE - 32'd4, 1'b0);
    idle();
    chk("top_word_err", 32'(obs_ls_err), 32'h0);
    cycle(1'b0, MEM_OFFSET, 1'b0, 1'b1, MEM_OFFSET - 32'd4, 1'b0);
    idle();
    chk("below_base_err", 32'(obs_ls_err), 32'h1);

    // reset mid-operation, then starvation restarts from zero
    cycle(1'b1, MEM_OFFSET + 32'h300, 1'b0, 1'b1, MEM_OFFSET + 32'h8, 1'b0);
    cycle(1'b1, MEM_OFFSET + 32'h300, 1'b0, 1'b1, MEM_OFFSET + 32'hc, 1'b0);
    cycle(1'b1, MEM_OFFSET + 32'h300, 1'b0, 1'b1, MEM_OFFSET + 32'h10, 1'b1);
    chk("rst_ls_gnt", 32'(obs_ls_gnt), 32'h0);
    idle();
    chk("rst_ls_valid", 32'(obs_ls_valid), 32'h0);
    gpat = '0;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, MEM_OFFSET + 32'h300, 1'b0, 1'b1, MEM_OFFSET + 32'(i * 4), 1'b0);
      gpat[i] = obs_if_gnt;
    end
    chk("rst_restart_pattern", gpat, 32'h10);

    // flush at the limit: LS granted, IF still first in line afterwards
    idle();
    for (int i = 0; i < 4; i++)
      cycle(1'b1, MEM_OFFSET + 32'h60, 1'b0, 1'b1, MEM_OFFSET + 32'(i * 4), 1'b0);
    cycle(1'b1, MEM_OFFSET + 32'h60, 1'b1, 1'b1, MEM_OFFSET + 32'h80, 1'b0);
    chk("limit_flush_ls", 32'(obs_ls_gnt), 32'h1);
    chk("limit_flush_if", 32'(obs_if_gnt), 32'h0);
    cycle(1'b1, MEM_OFFSET + 32'h60, 1'b0, 1'b1, MEM_OFFSET + 32'h84, 1'b0);
    chk("limit_after_flush_if", 32'(obs_if_gnt), 32'h1);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      rq_if = ($urandom_range(0, 3) != 0);
      rq_ls = ($urandom_range(0, 2) != 0);
      rfl   = ($urandom_range(0, 9) == 0);
      rrst  = ($urandom_range(0, 49) == 0);
      ra_if = rand_addr();
      ra_ls = rand_addr();
      cycle(rq_if, ra_if, rfl, rq_ls, ra_ls, rrst);
    end
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
